// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared state encoding, field widths and limits for the
//               mm:ss stopwatch.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    localparam int MIN_W = 7;
    localparam int SEC_W = 6;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2
    } state_t;

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/stopwatch_if.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_if
// Description : Control inputs and mm:ss/state outputs of the stopwatch.
// Revision    : 1.0 - initial release
// ============================================================================
interface stopwatch_if;
    import stopwatch_pkg::*;

    logic             start;
    logic             stop;
    logic             reset;
    logic [MIN_W-1:0] minutes;
    logic [SEC_W-1:0] seconds;
    logic [1:0]       current_state;

    modport master (
        output start, stop, reset,
        input  minutes, seconds, current_state
    );

    modport slave (
        input  start, stop, reset,
        output minutes, seconds, current_state
    );

endinterface : stopwatch_if
`default_nettype wire

// File: rtl/stopwatch_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_prescaler
// Description : Divides enabled clock edges by TICKS_PER_SEC and flags the
//               last edge of each period as a one-cycle tick.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_prescaler #(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    // A one-bit counter is kept even when TICKS_PER_SEC is 1 so the
    // compare stays legal; it simply never leaves zero in that case.
    localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == c_last);
    assign tick   = en && w_last;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule : stopwatch_prescaler
`default_nettype wire

// File: rtl/stopwatch.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch
// Description : mm:ss stopwatch with IDLE/RUNNING/PAUSED control FSM.
//               Define STOPWATCH_WRAP_EN to roll MAX_MIN:59 over to 00:00;
//               otherwise the count saturates there and pauses.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1,
    parameter int MAX_MIN       = 99
) (
    input  logic        clk,
    input  logic        rst,
    stopwatch_if.slave  bus
);

    localparam logic [MIN_W-1:0] c_max_min = MIN_W'(MAX_MIN);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [MIN_W-1:0] r_min;
    logic [MIN_W-1:0] w_min_nxt;
    logic [SEC_W-1:0] r_sec;
    logic [SEC_W-1:0] w_sec_nxt;
    logic             w_en;
    logic             w_tick;

    // The edge that samples stop or reset must not advance the prescaler.
    assign w_en = (r_state == ST_RUNNING) && !bus.stop && !bus.reset;

    stopwatch_prescaler #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.reset),
        .en   (w_en),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_min   <= '0;
            r_sec   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_min   <= w_min_nxt;
            r_sec   <= w_sec_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;
        if (bus.reset) begin
            w_state_nxt = ST_IDLE;
            w_min_nxt   = '0;
            w_sec_nxt   = '0;
        end else if (bus.stop) begin
            // From IDLE, stop only matters when start is also requested.
            if (r_state != ST_IDLE || bus.start) begin
                w_state_nxt = ST_PAUSED;
            end
        end else begin
            if (bus.start && r_state != ST_RUNNING) begin
                w_state_nxt = ST_RUNNING;
            end
            if (w_tick) begin
                if (r_sec != SEC_MAX) begin
                    w_sec_nxt = r_sec + 1'b1;
                end else if (r_min != c_max_min) begin
                    w_sec_nxt = '0;
                    w_min_nxt = r_min + 1'b1;
                end else begin
`ifdef STOPWATCH_WRAP_EN
                    w_sec_nxt = '0;
                    w_min_nxt = '0;
`else
                    w_state_nxt = ST_PAUSED;
`endif
                end
            end
        end
    end

    assign bus.minutes       = r_min;
    assign bus.seconds       = r_sec;
    assign bus.current_state = r_state;

endmodule : stopwatch
`default_nettype wire

// File: tb/tb_stopwatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch
// Description : Directed self-checking bench for stopwatch (TICKS_PER_SEC of
//               1 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    stopwatch_if sw_a ();
    stopwatch_if sw_b ();

    stopwatch #(
        .TICKS_PER_SEC (1),
        .MAX_MIN       (99)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (sw_a)
    );

    stopwatch #(
        .TICKS_PER_SEC (4),
        .MAX_MIN       (99)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (sw_b)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input int mm, input int ss, input int st);
        check({tag, "_min"},   int'(sw_a.minutes),       mm);
        check({tag, "_sec"},   int'(sw_a.seconds),       ss);
        check({tag, "_state"}, int'(sw_a.current_state), st);
    endtask

    task automatic check_b(input string tag, input int mm, input int ss, input int st);
        check({tag, "_min"},   int'(sw_b.minutes),       mm);
        check({tag, "_sec"},   int'(sw_b.seconds),       ss);
        check({tag, "_state"}, int'(sw_b.current_state), st);
    endtask

    initial begin
        sw_a.start = 1'b0; sw_a.stop = 1'b0; sw_a.reset = 1'b0;
        sw_b.start = 1'b0; sw_b.stop = 1'b0; sw_b.reset = 1'b0;

        rst = 1'b1;
        step(2);
        rst = 1'b0;
        check_a("reset", 0, 0, 0);
        check_b("reset_b", 0, 0, 0);

        sw_a.stop = 1'b1;
        step(5);
        sw_a.stop = 1'b0;
        check_a("idle_stop", 0, 0, 0);

        sw_a.start = 1'b1;
        step(1);
        sw_a.start = 1'b0;
        check_a("start_edge", 0, 0, 1);
        step(20);
        check_a("run20", 0, 20, 1);
        sw_a.stop = 1'b1;
        step(1);
        sw_a.stop = 1'b0;
        check_a("stop_edge", 0, 20, 2);
        step(5);
        check_a("paused_hold", 0, 20, 2);

        sw_a.start = 1'b1;
        step(1);
        sw_a.start = 1'b0;
        check_a("resume_edge", 0, 20, 1);
        step(10);
        check_a("resume10", 0, 30, 1);

        sw_a.reset = 1'b1;
        step(1);
        sw_a.reset = 1'b0;
        check_a("soft_reset", 0, 0, 0);
        sw_a.start = 1'b1;
        step(1);
        sw_a.start = 1'b0;
        step(59);
        check_a("sec59", 0, 59, 1);
        step(1);
        check_a("min_carry", 1, 0, 1);

        sw_a.reset = 1'b1;
        step(1);
        sw_a.reset = 1'b0;
        sw_a.start = 1'b1;
        step(1);
        sw_a.start = 1'b0;
        step(12);
        check_a("run12", 0, 12, 1);
        sw_a.reset = 1'b1;
        step(1);
        sw_a.reset = 1'b0;
        check_a("reset_running", 0, 0, 0);

        sw_a.start = 1'b1;
        sw_a.reset = 1'b1;
        step(1);
        sw_a.reset = 1'b0;
        sw_a.stop  = 1'b1;
        check_a("reset_and_start", 0, 0, 0);
        step(1);
        sw_a.stop  = 1'b0;
        check_a("start_and_stop_idle", 0, 0, 2);
        step(1);
        sw_a.start = 1'b0;
        check_a("start_from_paused", 0, 0, 1);

        step(5999);
        check_a("at_max", 99, 59, 1);
        step(1);
`ifdef STOPWATCH_WRAP_EN
        check_a("max_tick", 0, 0, 1);
        step(3);
        check_a("after_wrap", 0, 3, 1);
`else
        check_a("max_tick", 99, 59, 2);
        step(3);
        check_a("max_hold", 99, 59, 2);
        sw_a.start = 1'b1;
        step(1);
        sw_a.start = 1'b0;
        check_a("max_restart", 99, 59, 1);
        step(1);
        check_a("max_repause", 99, 59, 2);
`endif

        sw_b.start = 1'b1;
        step(1);
        sw_b.start = 1'b0;
        step(8);
        check_b("tps4_run8", 0, 2, 1);
        step(2);
        sw_b.stop = 1'b1;
        step(1);
        sw_b.stop = 1'b0;
        step(3);
        check_b("tps4_paused", 0, 2, 2);
        sw_b.start = 1'b1;
        step(1);
        sw_b.start = 1'b0;
        step(1);
        check_b("tps4_pre_tick", 0, 2, 1);
        step(1);
        check_b("tps4_prescale_held", 0, 3, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_stopwatch
`default_nettype wire

// File: doc/stopwatch.md
Name: stopwatch

Overview:
- Minutes:seconds stopwatch with start/stop/reset controls and a 3-state control FSM.
- Counts 00:00 to 99:59 from a prescaled tick derived from the single system clock.
- Drives binary minutes/seconds and the FSM state to a display or debug block.
- With TICKS_PER_SEC=1 the count advances once per clock, for fast simulation.

Parameters:
- TICKS_PER_SEC, 1, clock cycles per one-second increment; must be >= 1. Use 1 for simulation, the clock frequency in Hz for silicon.
- MAX_MIN, 99, highest minutes value; must be <= 127.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high; the sole hardware reset.
- start  in  1  level sampled each edge; requests RUNNING.
- stop  in  1  level sampled each edge; requests PAUSED.
- reset  in  1  soft clear; returns to IDLE at 00:00.
- minutes  out  7  minutes count, binary, 0..MAX_MIN.
- seconds  out  6  seconds count, binary, 0..59.
- current_state  out  2  FSM state: 0=IDLE, 1=RUNNING, 2=PAUSED; 3 is never driven.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- rst: on the edge where rst=1, state=IDLE, minutes=0, seconds=0, prescaler=0. rst overrides every other input.
- Control priority at each edge: rst > reset > stop > start.
- reset=1: same effect as rst (IDLE, 00:00, prescaler cleared), from any state.
- IDLE: start=1 -> RUNNING. stop alone is ignored.
- RUNNING: stop=1 -> PAUSED, and no increment on that edge. start=1 is ignored.
- PAUSED: start=1 -> RUNNING. Count and prescaler both hold.
- start and stop both high: stop wins; from IDLE the result is PAUSED with count still 00:00.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 only on edges where state is RUNNING at the start of the edge and no stop/reset/rst is sampled.
  - Tick fires on the edge where the prescaler equals TICKS_PER_SEC-1; the prescaler then wraps to 0.
- Increment on tick:
  - seconds+1.
  - seconds 59 -> 0 with minutes+1.
  - At MAX_MIN:59, behaviour is set by the optional feature below.
- Latency with TICKS_PER_SEC=1: start sampled at edge E makes RUNNING visible after E. First increment at E+1, then one per edge.
- Outputs are registered; no combinational path from inputs to outputs.
- Inputs are assumed synchronous to clk; no debouncing or edge detection. A held start or stop is equivalent to a pulse.

Optional Feature:
- Macro STOPWATCH_WRAP_EN.
- Defined: tick at MAX_MIN:59 wraps to 00:00 and the state stays RUNNING.
- Undefined (default): tick at MAX_MIN:59 holds MAX_MIN:59, the state goes to PAUSED, and later ticks are suppressed.

Decomposition:
- Shared package stopwatch_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUNNING=2'd1, ST_PAUSED=2'd2.
  - SEC_MAX=59.
  - output widths MIN_W=7, SEC_W=6.
- One sub-module, stopwatch_prescaler:
  - inputs: clk, rst, clr, en.
  - output: a one-cycle tick.
  - parameter: TICKS_PER_SEC.
- The top level holds the FSM and the mm:ss counter.

Test Plan (TICKS_PER_SEC=1 unless stated):
- rst high for 2 cycles, then low -> 00:00, current_state=0. Holding stop alone for 5 cycles changes nothing.
- Start pulse for 1 cycle, run 20 cycles, stop pulse for 1 cycle -> seconds=20 exactly at the stop edge. Then 5 more cycles -> still 00:20, state=2.
- From PAUSED at 00:20, start pulse, then 10 cycles -> 00:30, state=1.
- Run from 00:00 for 60 increments -> 01:00. Run to 00:59 then one more tick -> 01:00.
- At 99:59: with STOPWATCH_WRAP_EN the next tick gives 00:00, state=1. Without it, the count holds 99:59 and state=2.
- reset pulse while RUNNING at 00:12 -> next cycle 00:00, state=0. reset and start high together -> IDLE. TICKS_PER_SEC=4: 8 running cycles -> 00:02.
